ps2_rx: RTL and testbench

- PS/2 keyboard receiver for the Mercury baseboard top level.
- Takes raw PS2_CLK / PS2_DATA pad inputs and outputs validated scan-code bytes with a one-cycle valid strobe.
- Sits directly upstream of the seven-segment display path and runs on the 50 MHz application clock domain.

---
 rtl/ps2_rx.sv | 227 ++++++++++++++++++++++
 tb/tb_ps2_rx.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx.sv
// ps2_rx -- PS/2 keyboard receiver.
//
// Synchronizes the raw PS/2 clock/data pads into app_clk, de-glitches the
// clock with a FILTER_LEN-deep majority-free (all-equal) filter, and decodes
// 11-bit frames (start, 8 data LSB first, odd parity, stop). Good bytes are
// presented on data_out with a one-cycle data_valid strobe.
//
// Parameters:
//   FILTER_LEN     equal synchronized samples needed to move the filtered clock (2..16)
//   TIMEOUT_CYCLES app_clk cycles without a sample strobe before a partial frame aborts
//
// Ports:
//   app_clk      application clock
//   app_arst     asynchronous reset, active high
//   ps2_clk_in   raw PS/2 clock pad (async)
//   ps2_data_in  raw PS/2 data pad (async)
//   enable       1 = receive, 0 = hold the frame FSM in IDLE
//   data_out     last good scan-code byte
//   data_valid   one-cycle pulse, data_out updated on the same cycle
//   parity_err   one-cycle pulse, good stop bit but bad odd parity
//   frame_err    one-cycle pulse, bad stop bit or timeout
//   busy         frame FSM not in IDLE
//   seg0..3_out  (only with PS2_RX_HEX_SEG_EN) active-low 7-seg digits, A..G MSB-first:
//                seg0/seg1 = low/high nibble of newest byte, seg2/seg3 = previous byte
//
// Optional feature macro: PS2_RX_HEX_SEG_EN

module ps2_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       app_clk,
  input  logic       app_arst,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  input  logic       enable,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
`ifdef PS2_RX_HEX_SEG_EN
  ,
  output logic [6:0] seg0_out,
  output logic [6:0] seg1_out,
  output logic [6:0] seg2_out,
  output logic [6:0] seg3_out
`endif
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 2;
  localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TO_FIRE = TW'(TIMEOUT_CYCLES - 2);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  typedef struct packed {
    logic good;
    logic perr;
    logic ferr;
  } rx_res_t;

  // ---------------- synchronizers + clock filter ----------------
  logic [1:0]            clk_sync, dat_sync;
  logic [FILTER_LEN-1:0] flt_taps;
  logic                  clk_flt;
  logic                  stb_pre, strobe;
  logic                  clk_s, dat_s;
  logic                  all0, all1;

  assign clk_s   = clk_sync[1];
  assign dat_s   = dat_sync[1];
  assign all0    = ~|flt_taps;
  assign all1    = &flt_taps;
  // filtered clock is about to fall: the strobe is this, registered
  assign stb_pre = clk_flt & all0;

  always_ff @(posedge app_clk or posedge app_arst) begin
    if (app_arst) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      flt_taps <= '1;
      clk_flt  <= 1'b1;
      strobe   <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk_in};
      dat_sync <= {dat_sync[0], ps2_data_in};
      flt_taps <= {flt_taps[FILTER_LEN-2:0], clk_s};
      if (all0)      clk_flt <= 1'b0;
      else if (all1) clk_flt <= 1'b1;
      strobe   <= stb_pre;
    end
  end

  // ---------------- frame FSM ----------------
  state_t        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          par_q, par_d;
  logic [TW-1:0] to_cnt_q;
  logic          en_q, en_eff;
  rx_res_t       res_d;

  // enable must have been high for a full cycle, so a strobe landing on
  // the rising cycle of enable is dropped
  assign en_eff = enable & en_q;
  assign busy   = (state_q != IDLE);

  always_ff @(posedge app_clk or posedge app_arst) begin
    if (app_arst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      par_q     <= 1'b0;
      en_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      par_q     <= par_d;
      en_q      <= enable;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    res_d     = '0;
    if (!en_eff) begin
      state_d = IDLE;
    end else if (strobe) begin
      case (state_q)
        IDLE: begin
          if (!dat_s) begin
            bit_cnt_d = '0;
            state_d   = DATA;
          end
        end
        DATA: begin
          shreg_d   = {dat_s, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = dat_s;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (!dat_s)                 res_d.ferr = 1'b1;
          else if (^{shreg_q, par_q}) res_d.good = 1'b1;
          else                        res_d.perr = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE && to_cnt_q == TO_FIRE) begin
      // pulse is registered, so firing one count early lands frame_err on
      // the cycle the counter would read TIMEOUT_CYCLES-1
      state_d    = IDLE;
      res_d.ferr = 1'b1;
    end
  end

  // Cleared one cycle ahead of the strobe so it reads 0 in the strobe cycle
  // itself; held at 0 while the FSM sits (or lands) in IDLE.
  always_ff @(posedge app_clk or posedge app_arst) begin
    if (app_arst)                        to_cnt_q <= '0;
    else if (stb_pre || state_d == IDLE) to_cnt_q <= '0;
    else if (to_cnt_q != TO_MAX)         to_cnt_q <= to_cnt_q + 1'b1;
  end

  always_ff @(posedge app_clk or posedge app_arst) begin
    if (app_arst) begin
      data_out   <= 8'h00;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= res_d.good;
      parity_err <= res_d.perr;
      frame_err  <= res_d.ferr;
      if (res_d.good) data_out <= shreg_q;
    end
  end

`ifdef PS2_RX_HEX_SEG_EN
  // ---------------- hex display ----------------
  function automatic logic [6:0] hex2seg(input logic [3:0] h);
    hex2seg = 7'b1111111;
    case (h)
      4'h0: hex2seg = 7'b0000001;
      4'h1: hex2seg = 7'b1001111;
      4'h2: hex2seg = 7'b0010010;
      4'h3: hex2seg = 7'b0000110;
      4'h4: hex2seg = 7'b1001100;
      4'h5: hex2seg = 7'b0100100;
      4'h6: hex2seg = 7'b0100000;
      4'h7: hex2seg = 7'b0001111;
      4'h8: hex2seg = 7'b0000000;
      4'h9: hex2seg = 7'b0000100;
      4'hA: hex2seg = 7'b0001000;
      4'hB: hex2seg = 7'b1100000;
      4'hC: hex2seg = 7'b0110001;
      4'hD: hex2seg = 7'b1000010;
      4'hE: hex2seg = 7'b0110000;
      4'hF: hex2seg = 7'b0111000;
      default: hex2seg = 7'b1111111;
    endcase
  endfunction

  logic [3:0][6:0] seg_q;

  // newest byte shifts into digits 0/1, previous byte moves to 2/3
  always_ff @(posedge app_clk or posedge app_arst) begin
    if (app_arst)        seg_q <= {4{7'b0000001}};
    else if (data_valid) seg_q <= {seg_q[1], seg_q[0], hex2seg(data_out[7:4]), hex2seg(data_out[3:0])};
  end

  assign seg0_out = seg_q[0];
  assign seg1_out = seg_q[1];
  assign seg2_out = seg_q[2];
  assign seg3_out = seg_q[3];
`endif

endmodule

// File: tb/tb_ps2_rx.sv
// Bench for ps2_rx: reset checks, table of frames with constant expectations,
// corner sequences (timeout, glitch, enable, reset mid-frame) and random
// frames scored against a frame-level reference model.
module tb_ps2_rx;
  localparam int FL  = 8;
  localparam int TO  = 200;
  localparam int HP  = 20;   // half PS/2 bit period in app_clk cycles
  localparam int LAT = FL + 4; // pad fall of STOP -> result pulse (negedge count)

  localparam int K_GOOD = 1, K_PERR = 2, K_FERR = 3;

  logic       app_clk = 1'b0;
  logic       app_arst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       enable = 1'b1;
  logic [7:0] data_out;
  logic       data_valid, parity_err, frame_err, busy;
`ifdef PS2_RX_HEX_SEG_EN
  logic [6:0] seg0, seg1, seg2, seg3;
`endif

  ps2_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .app_clk(app_clk), .app_arst(app_arst),
    .ps2_clk_in(ps2_clk), .ps2_data_in(ps2_data), .enable(enable),
    .data_out(data_out), .data_valid(data_valid), .parity_err(parity_err),
    .frame_err(frame_err), .busy(busy)
`ifdef PS2_RX_HEX_SEG_EN
    , .seg0_out(seg0), .seg1_out(seg1), .seg2_out(seg2), .seg3_out(seg3)
`endif
  );

  always #10 app_clk = ~app_clk;

  int cyc = 0;
  always @(posedge app_clk) cyc <= cyc + 1;

  typedef struct {
    int         kind;
    int         cyc;
    logic [7:0] d;
  } ev_t;
  ev_t evq[$];
  int  overlap = 0;

  always @(negedge app_clk) begin
    ev_t e;
    if (data_valid || parity_err || frame_err) begin
      e.kind = data_valid ? K_GOOD : (parity_err ? K_PERR : K_FERR);
      e.cyc  = cyc;
      e.d    = data_out;
      evq.push_back(e);
    end
    if (int'(data_valid) + int'(parity_err) + int'(frame_err) > 1) overlap++;
  end

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge app_clk);
  endtask

  // bits[0] first; data set while clock high, clock low for HP cycles
  task automatic send_bits(input logic [10:0] bits, input int n, output int last_fall);
    last_fall = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge app_clk);
      ps2_data = bits[i];
      wait_cyc(HP);
      ps2_clk   = 1'b0;
      last_fall = cyc;
      wait_cyc(HP);
      ps2_clk   = 1'b1;
    end
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic pflip, input logic stop);
    logic par;
    par = (~^d) ^ pflip;
    return {stop, par, d, 1'b0};
  endfunction

  // exactly one event of the given kind at the given cycle, data_out and busy
  task automatic check_frame(input string nm, input int kind, input logic [7:0] dexp, input int ecyc);
    chk({nm, ".n_events"}, evq.size(), 1);
    if (evq.size() >= 1) begin
      chk({nm, ".kind"}, evq[0].kind, kind);
      chk({nm, ".cycle"}, evq[0].cyc, ecyc);
    end
    chk({nm, ".data_out"}, data_out, dexp);
    chk({nm, ".busy"}, busy, 0);
    evq.delete();
  endtask

  task automatic count_busy(input int n, output int nb);
    nb = 0;
    repeat (n) begin
      @(negedge app_clk);
      if (busy) nb++;
    end
  endtask

  // frame-level reference: odd parity over data+parity, stop bit dominant
  function automatic int ref_kind(input logic [7:0] d, input logic par, input logic stop);
    if (!stop) return K_FERR;
    if ((($countones(d) + int'(par)) % 2) == 1) return K_GOOD;
    return K_PERR;
  endfunction

  typedef struct {
    logic [7:0] d;
    logic       pflip;
    logic       stop;
    int         kind;
    logic [7:0] exp_out;
  } vec_t;

  initial begin
    vec_t       vt[8];
    int         lf, nb, k;
    logic [7:0] d, last_good;
    logic [10:0] fr;
    logic       pf, st;

    vt[0] = '{8'h1C, 1'b0, 1'b1, K_GOOD, 8'h1C};
    vt[1] = '{8'hF0, 1'b0, 1'b1, K_GOOD, 8'hF0};
    vt[2] = '{8'h1C, 1'b0, 1'b1, K_GOOD, 8'h1C};
    vt[3] = '{8'h22, 1'b0, 1'b1, K_GOOD, 8'h22};
    vt[4] = '{8'h1C, 1'b1, 1'b1, K_PERR, 8'h22};
    vt[5] = '{8'h1C, 1'b1, 1'b0, K_FERR, 8'h22};
    vt[6] = '{8'h00, 1'b0, 1'b0, K_FERR, 8'h22};
    vt[7] = '{8'hFF, 1'b0, 1'b1, K_GOOD, 8'hFF};

    // ---- reset ----
    wait_cyc(4);
    chk("rst.data_out", data_out, 0);
    chk("rst.data_valid", data_valid, 0);
    chk("rst.parity_err", parity_err, 0);
    chk("rst.frame_err", frame_err, 0);
    chk("rst.busy", busy, 0);
`ifdef PS2_RX_HEX_SEG_EN
    chk("rst.seg0", seg0, 7'b0000001);
    chk("rst.seg3", seg3, 7'b0000001);
`endif
    app_arst = 1'b0;
    wait_cyc(10);

    // ---- table of frames ----
    for (int i = 0; i < 8; i++) begin
      send_bits(mk_frame(vt[i].d, vt[i].pflip, vt[i].stop), 11, lf);
      wait_cyc(10);
      check_frame($sformatf("vec%0d", i), vt[i].kind, vt[i].exp_out, lf + LAT);
`ifdef PS2_RX_HEX_SEG_EN
      if (i == 2) begin
        chk("seg0_C", seg0, 7'b0110001);
        chk("seg1_1", seg1, 7'b1001111);
        chk("seg2_0", seg2, 7'b0000001);
        chk("seg3_F", seg3, 7'b0111000);
      end
`endif
    end
    last_good = 8'hFF;

    // ---- timeout after 4 data bits, then clean 0x5A ----
    send_bits(mk_frame(8'h5A, 1'b0, 1'b1), 5, lf);
    wait_cyc(TO + FL + 20);
    check_frame("timeout", K_FERR, last_good, lf + FL + 3 + TO - 1);
    send_bits(mk_frame(8'h5A, 1'b0, 1'b1), 11, lf);
    wait_cyc(10);
    check_frame("after_timeout", K_GOOD, 8'h5A, lf + LAT);
    last_good = 8'h5A;

    // ---- FL-1 cycle low glitch with data low: must not start a frame ----
    @(negedge app_clk);
    ps2_data = 1'b0;
    wait_cyc(HP);
    ps2_clk = 1'b0;
    wait_cyc(FL - 1);
    ps2_clk = 1'b1;
    count_busy(40, nb);
    chk("glitch.busy_cycles", nb, 0);
    chk("glitch.events", evq.size(), 0);
    ps2_data = 1'b1;

    // ---- FL cycle low pulse with data high: strobe in IDLE, no frame, no error ----
    wait_cyc(HP);
    ps2_clk = 1'b0;
    wait_cyc(FL);
    ps2_clk = 1'b1;
    count_busy(40, nb);
    chk("idle_hi.busy_cycles", nb, 0);
    chk("idle_hi.events", evq.size(), 0);

    // ---- enable dropped mid-frame ----
    fr = mk_frame(8'h1C, 1'b0, 1'b1);
    send_bits(fr, 5, lf);
    @(negedge app_clk);
    enable = 1'b0;
    wait_cyc(2);
    chk("en_off.busy", busy, 0);
    send_bits(fr >> 5, 6, lf);
    wait_cyc(10);
    enable = 1'b1;
    wait_cyc(10);
    chk("en_off.events", evq.size(), 0);
    chk("en_off.data_out", data_out, last_good);
    send_bits(mk_frame(8'h3C, 1'b0, 1'b1), 11, lf);
    wait_cyc(10);
    check_frame("after_enable", K_GOOD, 8'h3C, lf + LAT);
    last_good = 8'h3C;

    // ---- randomized frames vs reference model ----
    for (int i = 0; i < 16; i++) begin
      d  = 8'($urandom);
      pf = ($urandom_range(0, 3) == 0);
      st = ($urandom_range(0, 7) != 0);
      fr = mk_frame(d, pf, st);
      k  = ref_kind(d, fr[9], st);
      if (k == K_GOOD) last_good = d;
      send_bits(fr, 11, lf);
      wait_cyc(10);
      check_frame($sformatf("rand%0d_%02h", i, d), k, last_good, lf + LAT);
    end

    // ---- reset mid-frame ----
    send_bits(mk_frame(8'h33, 1'b0, 1'b1), 6, lf);
    @(negedge app_clk);
    app_arst = 1'b1;
    wait_cyc(1);
    chk("rst_mid.busy", busy, 0);
    chk("rst_mid.data_out", data_out, 0);
    wait_cyc(2);
    app_arst = 1'b0;
    wait_cyc(50);
    chk("rst_mid.events", evq.size(), 0);
    send_bits(mk_frame(8'h1C, 1'b0, 1'b1), 11, lf);
    wait_cyc(10);
    check_frame("after_rst", K_GOOD, 8'h1C, lf + LAT);

    chk("no_overlap", overlap, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
